comparador_serial_n: RTL and testbench

COMPARADOR_SERIAL_N -- requirements
Module: comparador_serial_n

---
 rtl/comparador_serial_n_if.sv | 27 ++
 rtl/comparador_serial_n.sv | 126 ++++++++++++
 tb/tb_comparador_serial_n.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/comparador_serial_n_if.sv
// Operand/handshake bundle for the serial comparator: start request, operands,
// cascade inputs on one side; registered result, busy and done pulse on the other.
interface comparador_serial_n_if #(
  parameter int N = 6
);
  logic         iniciar;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         ALBi;
  logic         AGBi;
  logic         AEBi;
  logic         ALBo;
  logic         AGBo;
  logic         AEBo;
  logic         ocupado;
  logic         pronto;

  modport master (
    output iniciar, A, B, ALBi, AGBi, AEBi,
    input  ALBo, AGBo, AEBo, ocupado, pronto
  );

  modport slave (
    input  iniciar, A, B, ALBi, AGBi, AEBi,
    output ALBo, AGBo, AEBo, ocupado, pronto
  );
endinterface

// File: rtl/comparador_serial_n.sv
// Serial magnitude comparator: walks K-bit slices of captured operands MSB first,
// stops at the first differing slice, and falls back to the cascade inputs on full equality.
module comparador_serial_n #(
  parameter int N = 6,
  parameter int K = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  comparador_serial_n_if.slave  bus
);
  localparam int S  = N / K;
  localparam int IW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {OCIOSO, COMPARA, FIM} state_t;

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_a, r_b, w_a_next, w_b_next;
  logic           r_albi, r_agbi, r_aebi;
  logic           w_albi_next, w_agbi_next, w_aebi_next;
  logic [IW-1:0]  r_idx, w_idx_next;
  logic           r_alb, r_agb, r_aeb;
  logic           w_alb_next, w_agb_next, w_aeb_next;
  logic           r_ocupado, r_pronto;

  logic [K-1:0]   w_slice_a [S];
  logic [K-1:0]   w_slice_b [S];
  logic [K-1:0]   w_cur_a, w_cur_b;

  for (genvar gi = 0; gi < S; gi++) begin : g_slices
    assign w_slice_a[gi] = r_a[gi*K +: K];
    assign w_slice_b[gi] = r_b[gi*K +: K];
  end

  assign w_cur_a = w_slice_a[r_idx];
  assign w_cur_b = w_slice_b[r_idx];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= OCIOSO;
      r_a       <= '0;
      r_b       <= '0;
      r_albi    <= 1'b0;
      r_agbi    <= 1'b0;
      r_aebi    <= 1'b0;
      r_idx     <= '0;
      r_alb     <= 1'b0;
      r_agb     <= 1'b0;
      r_aeb     <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_a       <= w_a_next;
      r_b       <= w_b_next;
      r_albi    <= w_albi_next;
      r_agbi    <= w_agbi_next;
      r_aebi    <= w_aebi_next;
      r_idx     <= w_idx_next;
      r_alb     <= w_alb_next;
      r_agb     <= w_agb_next;
      r_aeb     <= w_aeb_next;
      // Status flags are registered from the next state so they line up with it.
      r_ocupado <= (w_state_next != OCIOSO);
      r_pronto  <= (w_state_next == FIM);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_albi_next  = r_albi;
    w_agbi_next  = r_agbi;
    w_aebi_next  = r_aebi;
    w_idx_next   = r_idx;
    w_alb_next   = r_alb;
    w_agb_next   = r_agb;
    w_aeb_next   = r_aeb;

    unique case (r_state)
      OCIOSO: begin
        if (bus.iniciar) begin
          w_a_next     = bus.A;
          w_b_next     = bus.B;
          w_albi_next  = bus.ALBi;
          w_agbi_next  = bus.AGBi;
          w_aebi_next  = bus.AEBi;
          w_idx_next   = IW'(S - 1);
          w_state_next = COMPARA;
        end
      end
      COMPARA: begin
        if (w_cur_a > w_cur_b) begin
          w_alb_next   = 1'b0;
          w_agb_next   = 1'b1;
          w_aeb_next   = 1'b0;
          w_state_next = FIM;
        end else if (w_cur_a < w_cur_b) begin
          w_alb_next   = 1'b1;
          w_agb_next   = 1'b0;
          w_aeb_next   = 1'b0;
          w_state_next = FIM;
        end else if (r_idx != '0) begin
          w_idx_next   = r_idx - 1'b1;
        end else begin
          w_alb_next   = r_albi;
          w_agb_next   = r_agbi;
          w_aeb_next   = r_aebi;
          w_state_next = FIM;
        end
      end
      FIM: begin
        w_state_next = OCIOSO;
      end
      default: begin
        w_state_next = OCIOSO;
      end
    endcase
  end

  assign bus.ALBo    = r_alb;
  assign bus.AGBo    = r_agb;
  assign bus.AEBo    = r_aeb;
  assign bus.ocupado = r_ocupado;
  assign bus.pronto  = r_pronto;
endmodule

// File: tb/tb_comparador_serial_n.sv
// Bench for comparador_serial_n (N=6, K=2): table vectors, random vectors against a
// behavioural model, and hand sequences for ignore-while-busy, mid-run reset and back-to-back.
module tb_comparador_serial_n;
  localparam int N = 6;
  localparam int K = 2;
  localparam int S = N / K;

  logic clk;
  logic rst_n;
  int   cyc;
  int   cmp_count;
  int   err_count;

  comparador_serial_n_if #(.N(N)) bus ();

  comparador_serial_n #(.N(N), .K(K)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] res;   // {ALBo, AGBo, AEBo}
    int         cap;   // cycle count right after the capturing edge
    int         m;     // slices examined
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   casc;  // {ALBi, AGBi, AEBi}
    logic [2:0]   res;
    int           m;
  } vec_t;

  // Scoreboard: every pronto must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.pronto) begin
      cmp_count++;
      if (exp_q.size() == 0) begin
        err_count++;
        $display("FAIL unexpected_pronto at cycle %0d res=%b", cyc, {bus.ALBo, bus.AGBo, bus.AEBo});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({bus.ALBo, bus.AGBo, bus.AEBo} !== e.res) begin
          err_count++;
          $display("FAIL result got=%b want=%b", {bus.ALBo, bus.AGBo, bus.AEBo}, e.res);
        end else begin
          $display("result ok res=%b latency_cycle=%0d", e.res, cyc - e.cap + 1);
        end
        cmp_count++;
        if (cyc - e.cap + 1 != e.m + 1) begin
          err_count++;
          $display("FAIL latency got_cycle=%0d want_cycle=%0d", cyc - e.cap + 1, e.m + 1);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    cmp_count++;
    if (got !== want) begin
      err_count++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("check %s ok val=%0h", name, got);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after the capturing edge.
  task automatic start(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] casc,
                       input logic [2:0] res, input int m);
    exp_t e;
    bus.A       = a;
    bus.B       = b;
    {bus.ALBi, bus.AGBi, bus.AEBi} = casc;
    bus.iniciar = 1'b1;
    @(posedge clk);
    #1;
    bus.iniciar = 1'b0;
    e.res = res;
    e.cap = cyc;
    e.m   = m;
    exp_q.push_back(e);
  endtask

  task automatic wait_done();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      cmp_count++;
      err_count++;
      $display("FAIL pronto_timeout outstanding=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [2:0] casc, output logic [2:0] res, output int m);
    res = casc;
    m   = S;
    for (int s = S - 1; s >= 0; s--) begin
      if ((a >> (s * K)) != (b >> (s * K))) begin
        m   = S - s;
        res = (a > b) ? 3'b010 : 3'b100;
        break;
      end
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  vec_t vecs[8];

  initial begin
    cyc         = 0;
    cmp_count   = 0;
    err_count   = 0;
    bus.iniciar = 1'b0;
    bus.A       = '0;
    bus.B       = '0;
    bus.ALBi    = 1'b0;
    bus.AGBi    = 1'b0;
    bus.AEBi    = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("reset_outputs", {27'd0, bus.ALBo, bus.AGBo, bus.AEBo, bus.ocupado, bus.pronto}, 32'd0);

    vecs[0] = '{6'd37, 6'd45, 3'b000, 3'b100, 2};
    vecs[1] = '{6'd63, 6'd0,  3'b000, 3'b010, 1};
    vecs[2] = '{6'd21, 6'd21, 3'b001, 3'b001, 3};
    vecs[3] = '{6'd21, 6'd21, 3'b100, 3'b100, 3};
    vecs[4] = '{6'd0,  6'd0,  3'b010, 3'b010, 3};
    vecs[5] = '{6'd42, 6'd43, 3'b001, 3'b100, 3};
    vecs[6] = '{6'd48, 6'd47, 3'b001, 3'b010, 1};
    vecs[7] = '{6'd20, 6'd17, 3'b000, 3'b010, 2};

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].casc, vecs[i].res, vecs[i].m);
      check("ocupado_busy", {31'd0, bus.ocupado}, 32'd1);
      wait_done();
      @(posedge clk);
      #1;
    end
    check("ocupado_idle", {31'd0, bus.ocupado}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      logic [N-1:0] a, b;
      logic [2:0]   casc, res;
      int           m;
      a    = N'($urandom_range(0, 63));
      b    = (i % 3 == 0) ? a : N'($urandom_range(0, 63));
      casc = 3'b001 << $urandom_range(0, 2);
      model(a, b, casc, res, m);
      start(a, b, casc, res, m);
      wait_done();
      @(posedge clk);
      #1;
    end

    // Retrigger and input changes while busy must be ignored.
    start(6'd10, 6'd20, 3'b000, 3'b100, 1);
    bus.A       = 6'd60;
    bus.iniciar = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    bus.iniciar = 1'b0;
    check("single_pronto_drained", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    check("no_restart_ocupado", {31'd0, bus.ocupado}, 32'd1 - 32'd1);

    // Reset in the middle of a comparison aborts it with no pronto.
    start(6'd21, 6'd21, 3'b001, 3'b001, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("async_reset_outputs", {27'd0, bus.ALBo, bus.AGBo, bus.AEBo, bus.ocupado, bus.pronto}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("after_reset_idle", {31'd0, bus.ocupado}, 32'd0);

    start(6'd5, 6'd4, 3'b000, 3'b010, 3);
    wait_done();
    @(posedge clk);
    #1;
    // Back-to-back: the old result must hold through the new COMPARA.
    start(6'd0, 6'd63, 3'b000, 3'b100, 1);
    check("hold_during_compara", {29'd0, bus.ALBo, bus.AGBo, bus.AEBo}, 32'b010);
    wait_done();
    @(posedge clk);
    #1;
    check("result_after_b2b", {29'd0, bus.ALBo, bus.AGBo, bus.AEBo}, 32'b100);
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end
endmodule
